// File: rtl/onchip_mem_arbiter.sv
// Two-requester Avalon-MM arbiter sharing one single-port on-chip RAM.
// Round-robin grant with a bounded hold; read data is routed back to the issuer one cycle later.
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   rq0_address,
   input  logic [DATA_W/8-1:0] rq0_byteenable,
   input  logic                rq0_read,
   input  logic                rq0_write,
   input  logic [DATA_W-1:0]   rq0_writedata,
   output logic                rq0_waitrequest,
   output logic [DATA_W-1:0]   rq0_readdata,
   output logic                rq0_readdatavalid,

   input  logic [ADDR_W-1:0]   rq1_address,
   input  logic [DATA_W/8-1:0] rq1_byteenable,
   input  logic                rq1_read,
   input  logic                rq1_write,
   input  logic [DATA_W-1:0]   rq1_writedata,
   output logic                rq1_waitrequest,
   output logic [DATA_W-1:0]   rq1_readdata,
   output logic                rq1_readdatavalid,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W   = DATA_W / 8;
   localparam int HOLD_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byteenable;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] writedata;
   } cmd_t;

   cmd_t              cmd0, cmd1, sel;
   logic [1:0]        req;
   logic              grant_valid;
   logic              grant_idx;
   logic              keep_last;
   logic              issue_read;

   logic              last_grant;
   logic [HOLD_W-1:0] hold_cnt;
   logic              rd_valid;
   logic              rd_tag;

   assign cmd0 = '{rq0_address, rq0_byteenable, rq0_read, rq0_write, rq0_writedata};
   assign cmd1 = '{rq1_address, rq1_byteenable, rq1_read, rq1_write, rq1_writedata};
   assign req  = {rq1_read | rq1_write, rq0_read | rq0_write};

   // hold_cnt==0 means the previous cycle was idle, so last_grant holds no claim.
   assign keep_last = (hold_cnt != '0) && (hold_cnt < HOLD_W'(MAX_HOLD));

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      if (!reset) begin
         unique case (req)
            2'b01: grant_valid = 1'b1;
            2'b10: begin
               grant_valid = 1'b1;
               grant_idx   = 1'b1;
            end
            2'b11: begin
               grant_valid = 1'b1;
               grant_idx   = keep_last ? last_grant : ~last_grant;
            end
            default: ;
         endcase
      end
   end

   assign sel        = grant_idx ? cmd1 : cmd0;
   // Read+write together is treated as a write and never returns data.
   assign issue_read = grant_valid & sel.read & ~sel.write;

   assign rq0_waitrequest = ~(grant_valid & ~grant_idx & req[0]);
   assign rq1_waitrequest = ~(grant_valid &  grant_idx & req[1]);

   assign mem_address    = sel.address;
   assign mem_byteenable = sel.byteenable;
   assign mem_writedata  = sel.writedata;
   assign mem_chipselect = grant_valid;
   assign mem_write      = grant_valid & sel.write;
   assign mem_clken      = ~reset;

   // NOTE: sequential state uses non-blocking assignments and clears asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         hold_cnt   <= '0;
         rd_valid   <= 1'b0;
         rd_tag     <= 1'b0;
      end else begin
         rd_valid <= issue_read;
         rd_tag   <= grant_idx;
         if (grant_valid) begin
            last_grant <= grant_idx;
            if (grant_idx == last_grant && hold_cnt != '0) begin
               if (hold_cnt < HOLD_W'(MAX_HOLD))
                  hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
               hold_cnt <= HOLD_W'(1);
            end
         end else begin
            hold_cnt <= '0;
         end
      end
   end

   assign rq0_readdatavalid = rd_valid & ~rd_tag;
   assign rq1_readdatavalid = rd_valid &  rd_tag;
   assign rq0_readdata      = mem_readdata;
   assign rq1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: bench-side RAM, behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_onchip_mem_arbiter;

   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 32;
   localparam int BE_W     = DATA_W / 8;
   localparam int MAX_HOLD = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] rq0_address, rq1_address;
   logic [BE_W-1:0]   rq0_byteenable, rq1_byteenable;
   logic              rq0_read, rq1_read, rq0_write, rq1_write;
   logic [DATA_W-1:0] rq0_writedata, rq1_writedata;
   logic              rq0_waitrequest, rq1_waitrequest;
   logic [DATA_W-1:0] rq0_readdata, rq1_readdata;
   logic              rq0_readdatavalid, rq1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset),
      .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable), .rq0_read(rq0_read),
      .rq0_write(rq0_write), .rq0_writedata(rq0_writedata), .rq0_waitrequest(rq0_waitrequest),
      .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
      .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable), .rq1_read(rq1_read),
      .rq1_write(rq1_write), .rq1_writedata(rq1_writedata), .rq1_waitrequest(rq1_waitrequest),
      .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Bench RAM: registered address, unregistered q.
   logic [DATA_W-1:0] ram [1024];
   logic [ADDR_W-1:0] ram_addr_q;
   assign mem_readdata = ram[ram_addr_q];

   always @(posedge clk) begin
      if (mem_clken) begin
         if (mem_chipselect && mem_write)
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         ram_addr_q <= mem_address;
      end
   end

   function automatic logic [DATA_W-1:0] init_word(int i);
      return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: streak = grants in a row to the current owner, returns via a one-deep queue.
   logic [DATA_W-1:0] model_mem [1024];
   int                m_last, m_streak, m_g;
   bit                m_granted;
   bit                m_pend;
   int                m_pend_tag;
   logic [DATA_W-1:0] m_pend_data;
   bit                m_r0, m_r1, m_rd, m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [BE_W-1:0]   m_be;
   logic [DATA_W-1:0] m_wd;

   initial begin : model
      m_last = 1; m_streak = 0; m_pend = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_wait0", rq0_waitrequest, 1);
            check("rst_wait1", rq1_waitrequest, 1);
            check("rst_cs", mem_chipselect, 0);
            check("rst_write", mem_write, 0);
            check("rst_rdv0", rq0_readdatavalid, 0);
            check("rst_rdv1", rq1_readdatavalid, 0);
            check("rst_clken", mem_clken, 0);
            m_last = 1; m_streak = 0; m_pend = 0;
         end else begin
            check("m_clken", mem_clken, 1);
            check("m_rdv0", rq0_readdatavalid, m_pend && m_pend_tag == 0);
            check("m_rdv1", rq1_readdatavalid, m_pend && m_pend_tag == 1);
            if (m_pend && m_pend_tag == 0) check("m_rdata0", rq0_readdata, m_pend_data);
            if (m_pend && m_pend_tag == 1) check("m_rdata1", rq1_readdata, m_pend_data);
            m_pend = 0;

            m_r0 = rq0_read | rq0_write;
            m_r1 = rq1_read | rq1_write;
            m_granted = m_r0 | m_r1;
            if (m_r0 && m_r1)
               m_g = (m_streak > 0 && m_streak < MAX_HOLD) ? m_last : 1 - m_last;
            else
               m_g = m_r0 ? 0 : 1;

            check("m_wait0", rq0_waitrequest, !(m_granted && m_g == 0));
            check("m_wait1", rq1_waitrequest, !(m_granted && m_g == 1));
            check("m_cs", mem_chipselect, m_granted);

            if (m_granted) begin
               if (m_g == 0) begin
                  m_rd = rq0_read; m_wr = rq0_write; m_addr = rq0_address;
                  m_be = rq0_byteenable; m_wd = rq0_writedata;
               end else begin
                  m_rd = rq1_read; m_wr = rq1_write; m_addr = rq1_address;
                  m_be = rq1_byteenable; m_wd = rq1_writedata;
               end
               check("m_write", mem_write, m_wr);
               check("m_addr", mem_address, m_addr);
               if (m_wr) begin
                  check("m_be", mem_byteenable, m_be);
                  check("m_wdata", mem_writedata, m_wd);
                  for (int b = 0; b < BE_W; b++)
                     if (m_be[b]) model_mem[m_addr][8*b +: 8] = m_wd[8*b +: 8];
               end else if (m_rd) begin
                  m_pend = 1; m_pend_tag = m_g; m_pend_data = model_mem[m_addr];
               end
               m_streak = (m_g == m_last && m_streak > 0) ? m_streak + 1 : 1;
               m_last = m_g;
            end else begin
               check("m_write_idle", mem_write, 0);
               m_streak = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      rq0_read = 0; rq0_write = 0; rq0_address = '0; rq0_byteenable = '0; rq0_writedata = '0;
      rq1_read = 0; rq1_write = 0; rq1_address = '0; rq1_byteenable = '0; rq1_writedata = '0;
   endtask

   task automatic drive(int n, bit rd, bit wr, logic [ADDR_W-1:0] a, logic [BE_W-1:0] be,
                        logic [DATA_W-1:0] d);
      if (n == 0) begin
         rq0_read = rd; rq0_write = wr; rq0_address = a; rq0_byteenable = be; rq0_writedata = d;
      end else begin
         rq1_read = rd; rq1_write = wr; rq1_address = a; rq1_byteenable = be; rq1_writedata = d;
      end
   endtask

   task automatic do_reset();
      cyc(); idle(); reset = 1;
      cyc(); cyc(); reset = 0;
   endtask

   bit exp_w0 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   int i0, i1, n0, n1;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i] = init_word(i);
         model_mem[i] = init_word(i);
      end
      ram_addr_q = '0;
      reset = 1;
      idle();
      repeat (3) cyc();
      reset = 0;

      // Single read after reset
      cyc(); drive(0, 1, 0, 10'h005, 4'hF, '0); smp();
      check("t1_wait0", rq0_waitrequest, 0);
      check("t1_wait1", rq1_waitrequest, 1);
      check("t1_addr", mem_address, 10'h005);
      cyc(); idle(); smp();
      check("t1_rdv0", rq0_readdatavalid, 1);
      check("t1_rdata0", rq0_readdata, 32'h1005_0005);
      check("t1_rdv1", rq1_readdatavalid, 0);

      // Continuous contention on writes from reset
      do_reset();
      i0 = 0; i1 = 0;
      for (int k = 0; k < 9; k++) begin
         cyc();
         drive(0, 0, 1, 10'(10'h100 + i0), 4'hF, 32'hA000_0000 + 32'(i0));
         drive(1, 0, 1, 10'(10'h200 + i1), 4'hF, 32'hB000_0000 + 32'(i1));
         smp();
         check($sformatf("t2_wait0_%0d", k), rq0_waitrequest, exp_w0[k]);
         check($sformatf("t2_wait1_%0d", k), rq1_waitrequest, !exp_w0[k]);
         if (!rq0_waitrequest) i0++;
         if (!rq1_waitrequest) i1++;
      end
      cyc(); idle(); drive(1, 1, 0, 10'h203, 4'hF, '0);
      cyc(); idle(); smp();
      check("t2_rdv1", rq1_readdatavalid, 1);
      check("t2_rdata1", rq1_readdata, 32'hB000_0003);

      // Partial write then read on the next cycle
      cyc(); drive(0, 0, 1, 10'h010, 4'h3, 32'hDEAD_BEEF); smp();
      check("t3_wait0", rq0_waitrequest, 0);
      cyc(); idle(); drive(1, 1, 0, 10'h010, 4'hF, '0); smp();
      check("t3_wait1", rq1_waitrequest, 0);
      cyc(); idle(); smp();
      check("t3_rdv1", rq1_readdatavalid, 1);
      check("t3_rdata1", rq1_readdata, 32'h1010_BEEF);
      check("t3_rdv0", rq0_readdatavalid, 0);

      // Both read continuously: count routed returns
      do_reset();
      n0 = 0; n1 = 0;
      for (int k = 0; k < 13; k++) begin
         cyc();
         if (k < 12) begin
            drive(0, 1, 0, 10'h001, 4'hF, '0);
            drive(1, 1, 0, 10'h002, 4'hF, '0);
         end else begin
            idle();
         end
         smp();
         if (rq0_readdatavalid) begin
            n0++;
            check("t4_rdata0", rq0_readdata, 32'h1001_0001);
         end
         if (rq1_readdatavalid) begin
            n1++;
            check("t4_rdata1", rq1_readdata, 32'h1002_0002);
         end
      end
      check("t4_count0", n0, 8);
      check("t4_count1", n1, 4);

      // Reset right after an accepted read drops the return
      cyc(); idle(); drive(1, 1, 0, 10'h020, 4'hF, '0); smp();
      check("t5_wait1", rq1_waitrequest, 0);
      cyc(); reset = 1; drive(0, 0, 1, 10'h021, 4'hF, 32'h1234_5678); smp();
      check("t5_rdv1_a", rq1_readdatavalid, 0);
      check("t5_cs", mem_chipselect, 0);
      cyc(); smp();
      check("t5_rdv1_b", rq1_readdatavalid, 0);
      cyc(); reset = 0; idle();
      drive(0, 1, 0, 10'h030, 4'hF, '0);
      drive(1, 1, 0, 10'h031, 4'hF, '0);
      smp();
      check("t5_wait0", rq0_waitrequest, 0);
      check("t5_wait1", rq1_waitrequest, 1);
      check("t5_rdv1_c", rq1_readdatavalid, 0);
      cyc(); idle(); smp();
      check("t5_rdv0", rq0_readdatavalid, 1);
      check("t5_rdv1_d", rq1_readdatavalid, 0);

      // Idle cycles, then a lone rq1, then contention after idle
      for (int k = 0; k < 3; k++) begin
         cyc(); smp();
         check($sformatf("t6_cs_idle_%0d", k), mem_chipselect, 0);
      end
      cyc(); drive(1, 1, 0, 10'h3FF, 4'hF, '0); smp();
      check("t6_wait1", rq1_waitrequest, 0);
      check("t6_addr", mem_address, 10'h3FF);
      check("t6_cs", mem_chipselect, 1);
      cyc(); idle(); smp();
      check("t6_rdv1", rq1_readdatavalid, 1);
      check("t6_rdata1", rq1_readdata, 32'h13FF_03FF);
      cyc();
      drive(0, 0, 1, 10'h040, 4'hF, 32'h0000_0040);
      drive(1, 0, 1, 10'h041, 4'hF, 32'h0000_0041);
      smp();
      check("t6_wait0_after_idle", rq0_waitrequest, 0);
      check("t6_wait1_after_idle", rq1_waitrequest, 1);
      cyc(); idle();
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
